// File: rtl/key_beep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : key_beep_ctrl
//  Purpose  : Turns a debounced key-press event into a burst of BEEP_NUM
//             square-wave tone segments for a passive buzzer, separated by
//             silent gaps. Reports burst activity on busy and completion on
//             done.
//  Ports    : sys_clk  - system clock, rising edge
//             sys_rst  - synchronous active-high reset
//             keyflag  - one-cycle pulse, debounced level just settled
//             keyvalue - settled key level (0 = pressed), valid with keyflag
//             beep     - buzzer drive (square wave during a tone segment)
//             busy     - high while a burst is in progress
//             done     - one-cycle pulse when a burst completes
//  Options  : `define BEEP_RETRIGGER_EN to let a press during a burst restart
//             the burst from its first segment (no done for the aborted one).
//  Revision : 1.0 - initial release
// ============================================================================
module key_beep_ctrl #(
  parameter int unsigned HALF_PERIOD = 25_000,
  parameter int unsigned ON_CYCLES   = 5_000_000,
  parameter int unsigned OFF_CYCLES  = 5_000_000,
  parameter int unsigned BEEP_NUM    = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic keyflag,
  input  logic keyvalue,
  output logic beep,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic [31:0] HALF_LAST = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] ON_LAST   = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LAST  = 32'(OFF_CYCLES - 1);
  localparam logic [31:0] SEG_LAST  = 32'(BEEP_NUM - 1);

  state_t      state, state_n;
  logic [31:0] on_cnt, on_cnt_n;
  logic [31:0] off_cnt, off_cnt_n;
  logic [31:0] half_cnt, half_cnt_n;
  logic [31:0] seg_idx, seg_idx_n;
  logic        tone, tone_n;
  logic        done_n;
  logic        press;

  // Release events (keyvalue=1) never start anything.
  assign press = keyflag & ~keyvalue;

  always_comb begin
    state_n    = state;
    on_cnt_n   = on_cnt;
    off_cnt_n  = off_cnt;
    half_cnt_n = half_cnt;
    seg_idx_n  = seg_idx;
    tone_n     = tone;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (press) begin
          state_n    = S_ON;
          on_cnt_n   = '0;
          half_cnt_n = '0;
          seg_idx_n  = '0;
          tone_n     = 1'b1;
        end
      end

      S_ON: begin
        if (on_cnt == ON_LAST) begin
          if (seg_idx == SEG_LAST) begin
            // Last segment ends the burst with no trailing gap.
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n   = S_OFF;
            off_cnt_n = '0;
          end
        end else begin
          on_cnt_n = on_cnt + 32'd1;
          if (half_cnt == HALF_LAST) begin
            half_cnt_n = '0;
            tone_n     = ~tone;
          end else begin
            half_cnt_n = half_cnt + 32'd1;
          end
        end
      end

      S_OFF: begin
        if (off_cnt == OFF_LAST) begin
          state_n    = S_ON;
          seg_idx_n  = seg_idx + 32'd1;
          on_cnt_n   = '0;
          half_cnt_n = '0;
          tone_n     = 1'b1;
        end else begin
          off_cnt_n = off_cnt + 32'd1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

`ifdef BEEP_RETRIGGER_EN
    // A press during a burst (including its final ON cycle) restarts it and
    // swallows the done pulse of the aborted burst.
    if (press && (state != S_IDLE)) begin
      state_n    = S_ON;
      on_cnt_n   = '0;
      half_cnt_n = '0;
      seg_idx_n  = '0;
      tone_n     = 1'b1;
      done_n     = 1'b0;
    end
`endif
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe, one cycle after the triggering edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      on_cnt   <= '0;
      off_cnt  <= '0;
      half_cnt <= '0;
      seg_idx  <= '0;
      tone     <= 1'b0;
      beep     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      on_cnt   <= on_cnt_n;
      off_cnt  <= off_cnt_n;
      half_cnt <= half_cnt_n;
      seg_idx  <= seg_idx_n;
      tone     <= tone_n;
      beep     <= (state_n == S_ON) && tone_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_beep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_beep_ctrl
//  Purpose  : Scoreboard bench for key_beep_ctrl. Stimulus pushes per-cycle
//             expected (beep, busy, done) values tagged with the cycle they
//             apply to; a monitor pops and compares them on falling edges.
//             Bench configuration: HALF_PERIOD=2, ON_CYCLES=8, OFF_CYCLES=4,
//             BEEP_NUM=2.
//  Revision : 1.1 - direct output checks added
// ============================================================================
module tb_key_beep_ctrl;

    logic r_clk      = 1'b0;
    logic r_rst      = 1'b1;
    logic r_keyflag  = 1'b0;
    logic r_keyvalue = 1'b1;
    logic w_beep, w_busy, w_done;

    key_beep_ctrl #(
        .HALF_PERIOD(2),
        .ON_CYCLES  (8),
        .OFF_CYCLES (4),
        .BEEP_NUM   (2)
    ) u_dut (
        .sys_clk (r_clk),
        .sys_rst (r_rst),
        .keyflag (r_keyflag),
        .keyvalue(r_keyvalue),
        .beep    (w_beep),
        .busy    (w_busy),
        .done    (w_done)
    );

    always #5 r_clk = ~r_clk;

    int r_cyc = 0;
    always @(posedge r_clk) r_cyc <= r_cyc + 1;

    typedef struct {
        int    cyc;
        bit    beep;
        bit    busy;
        bit    done;
        string name;
    } exp_t;

    exp_t r_q[$];
    int   r_n_tests = 0;
    int   r_n_fail  = 0;

    // Expected outputs k cycles into a burst (k=0 is the first busy cycle).
    // 8 ON cycles (tone 1,1,0,0,...), 4 silent, 8 ON, then the done cycle.
    function automatic bit exp_beep(int k);
        if (k < 8)       return ((k / 2) % 2) == 0;
        else if (k < 12) return 1'b0;
        else if (k < 20) return (((k - 12) / 2) % 2) == 0;
        else             return 1'b0;
    endfunction

    function automatic void push(int c, bit b, bit bz, bit d, string nm);
        exp_t e;
        e.cyc = c; e.beep = b; e.busy = bz; e.done = d; e.name = nm;
        r_q.push_back(e);
    endfunction

    // Push burst entries k_from..k_to starting at cycle base; k=20 is done,
    // k>20 are idle cycles after the burst.
    function automatic void push_pattern(int base, int k_from, int k_to, string nm);
        for (int k = k_from; k <= k_to; k++)
            push(base + k, exp_beep(k), k < 20, k == 20, nm);
    endfunction

    function automatic void push_idle(int from, int n, string nm);
        for (int i = 0; i < n; i++) push(from + i, 1'b0, 1'b0, 1'b0, nm);
    endfunction

    // Monitor: outputs are sampled on falling edges, away from the active edge.
    always @(negedge r_clk) begin
        while (r_q.size() > 0 && r_q[0].cyc < r_cyc) begin
            r_n_tests++;
            r_n_fail++;
            $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                     r_q[0].name, r_q[0].cyc, r_cyc);
            void'(r_q.pop_front());
        end
        if (r_q.size() > 0 && r_q[0].cyc == r_cyc) begin
            exp_t e;
            e = r_q.pop_front();
            r_n_tests++;
            if (w_beep !== e.beep || w_busy !== e.busy || w_done !== e.done) begin
                r_n_fail++;
                $display("FAIL %s cyc=%0d: got beep/busy/done=%b%b%b required %b%b%b",
                         e.name, r_cyc, w_beep, w_busy, w_done, e.beep, e.busy, e.done);
            end
        end
    end

    task automatic tick();
        @(negedge r_clk);
    endtask

    task automatic wait_until(int c);
        while (r_cyc < c) tick();
    endtask

    task automatic press_now();
        r_keyflag  = 1'b1;
        r_keyvalue = 1'b0;
    endtask

    task automatic idle_inputs();
        r_keyflag  = 1'b0;
        r_keyvalue = 1'b1;
    endtask

    initial begin
        int base;

        // ---- Reset held 3 cycles with keyflag toggling ----
        tick();
        for (int i = 0; i < 3; i++) begin
            r_keyflag  = ~r_keyflag;
            r_keyvalue = 1'b0;
            push(r_cyc + 1, 1'b0, 1'b0, 1'b0, "reset");
            tick();
        end
        r_rst = 1'b0;
        idle_inputs();
        push_idle(r_cyc + 1, 2, "reset_release");
        tick();
        r_n_tests++;
        if (w_beep !== 1'b0 || w_busy !== 1'b0 || w_done !== 1'b0) begin
            r_n_fail++;
            $display("FAIL reset_direct: beep/busy/done=%b%b%b", w_beep, w_busy, w_done);
        end
        tick();

        // ---- Single press ----
        press_now();
        base = r_cyc + 1;
        push_pattern(base, 0, 22, "single_press");
        tick();
        idle_inputs();
        r_n_tests++;
        if (w_beep !== 1'b1 || w_busy !== 1'b1) begin
            r_n_fail++;
            $display("FAIL single_press_direct: beep/busy=%b%b", w_beep, w_busy);
        end
        wait_until(base + 23);
        r_n_tests++;
        if (w_busy !== 1'b0 || w_done !== 1'b0) begin
            r_n_fail++;
            $display("FAIL single_press_end_direct: busy/done=%b%b", w_busy, w_done);
        end

        // ---- Release event while idle ----
        r_keyflag  = 1'b1;
        r_keyvalue = 1'b1;
        push_idle(r_cyc + 1, 4, "release_ignored");
        tick();
        idle_inputs();
        wait_until(r_cyc + 4);

        // ---- Second press at busy cycle 10 ----
        press_now();
        base = r_cyc + 1;
`ifdef BEEP_RETRIGGER_EN
        push_pattern(base, 0, 9, "midburst_retrig");
        push_pattern(base + 10, 0, 22, "midburst_retrig");
`else
        push_pattern(base, 0, 22, "midburst_ignored");
`endif
        tick();
        idle_inputs();
        wait_until(base + 9);
        press_now();
        tick();
        idle_inputs();
`ifdef BEEP_RETRIGGER_EN
        wait_until(base + 33);
`else
        wait_until(base + 23);
`endif

        // ---- Press coinciding with the final ON cycle ----
        press_now();
        base = r_cyc + 1;
`ifdef BEEP_RETRIGGER_EN
        push_pattern(base, 0, 19, "final_cycle_retrig");
        push_pattern(base + 20, 0, 22, "final_cycle_retrig");
`else
        push_pattern(base, 0, 22, "final_cycle_ignored");
`endif
        tick();
        idle_inputs();
        wait_until(base + 19);
        press_now();
        tick();
        idle_inputs();
`ifdef BEEP_RETRIGGER_EN
        wait_until(base + 43);
`else
        wait_until(base + 23);
`endif

        // ---- Reset mid-burst at busy cycle 5 ----
        press_now();
        base = r_cyc + 1;
        push_pattern(base, 0, 4, "reset_midburst");
        push_idle(base + 5, 6, "reset_midburst");
        tick();
        idle_inputs();
        wait_until(base + 4);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        r_n_tests++;
        if (w_beep !== 1'b0 || w_busy !== 1'b0 || w_done !== 1'b0) begin
            r_n_fail++;
            $display("FAIL reset_midburst_direct: beep/busy/done=%b%b%b",
                     w_beep, w_busy, w_done);
        end
        wait_until(base + 11);

        // ---- Normal burst after mid-burst reset ----
        press_now();
        base = r_cyc + 1;
        push_pattern(base, 0, 22, "after_reset");
        tick();
        idle_inputs();
        wait_until(base + 23);

        // ---- Drain scoreboard with a bounded wait ----
        for (int i = 0; i < 50 && r_q.size() > 0; i++) tick();
        while (r_q.size() > 0) begin
            r_n_tests++;
            r_n_fail++;
            $display("FAIL %s: cycle %0d expectation left unchecked", r_q[0].name, r_q[0].cyc);
            void'(r_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", r_n_tests, r_n_fail);
        $finish;
    end

endmodule
`default_nettype wire
